// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - operation and state types for the execute-stage multiply/divide unit
package riscv_defines;

    typedef enum logic [3:0] {
        MD_MUL    = 4'd0,
        MD_MULH   = 4'd1,
        MD_MULHSU = 4'd2,
        MD_MULHU  = 4'd3,
        MD_DIV    = 4'd4,
        MD_DIVU   = 4'd5,
        MD_REM    = 4'd6,
        MD_REMU   = 4'd7
    } mdcontrol_t;

    // MD_FAST is the single non-iterating cycle used by illegal and early-out operations
    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_FAST,
        MD_DONE
    } md_state_t;

    function automatic logic md_legal(input mdcontrol_t op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
                          MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic md_is_div(input mdcontrol_t op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic md_a_signed(input mdcontrol_t op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic md_b_signed(input mdcontrol_t op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/exec_muldiv_special.sv
// rtl/exec_muldiv_special.sv - detects divide-by-zero, signed overflow and zero multiply operands
module exec_muldiv_special
    import riscv_defines::*;
#(
    parameter int XLEN = 32
) (
    input  mdcontrol_t        op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic              hit_o,
    output logic [XLEN-1:0]   result_o
);

    logic is_rem;
    logic div_zero;
    logic ovf;
    logic mul_zero;

    always_comb begin
        is_rem   = (op_i == MD_REM) || (op_i == MD_REMU);
        div_zero = md_is_div(op_i) && (b_i == '0);
        ovf      = ((op_i == MD_DIV) || (op_i == MD_REM))
                   && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
        mul_zero = md_legal(op_i) && !md_is_div(op_i) && ((a_i == '0) || (b_i == '0));
        hit_o    = div_zero | ovf | mul_zero;
        result_o = '0;
        if (div_zero) begin
            result_o = is_rem ? a_i : '1;
        end else if (ovf) begin
            result_o = is_rem ? '0 : a_i;
        end
    end

endmodule

// File: rtl/exec_muldiv.sv
// rtl/exec_muldiv.sv - radix-2 iterative RV32M multiply/divide unit with valid/ready in and out
// Define MULDIV_EARLY_OUT_EN to resolve zero/overflow cases in one cycle without iterating.
module exec_muldiv
    import riscv_defines::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    input  mdcontrol_t        mdcontrol,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic              out_err,
    output logic              busy
);

    localparam int CW = $clog2(XLEN);

    md_state_t          state_q, state_d;
    mdcontrol_t         op_q;
    logic               illegal_q, neg_q, err_q;
    logic [CW-1:0]      cnt_q;
    logic [XLEN-1:0]    hi_q, lo_q, b_q, res_q;

    logic               accept, last_iter, fast_take, spec_hit;
    logic               a_neg, b_neg, neg_d, div_ge;
    logic [XLEN-1:0]    a_mag, b_mag, spec_res, hi_nx, lo_nx, final_res;
    logic [XLEN:0]      mul_sum, div_sh;
    logic [2*XLEN-1:0]  prod_s;

`ifdef MULDIV_EARLY_OUT_EN
    exec_muldiv_special #(.XLEN(XLEN)) u_special (
        .op_i     (mdcontrol),
        .a_i      (in_a),
        .b_i      (in_b),
        .hit_o    (spec_hit),
        .result_o (spec_res)
    );
`else
    assign spec_hit = 1'b0;
    assign spec_res = '0;
`endif

    assign accept    = in_valid & in_ready;
    assign fast_take = !md_legal(mdcontrol) | spec_hit;
    assign last_iter = (cnt_q == CW'(XLEN-1));

    // Signed operands become magnitudes; the result sign is re-applied on write-back
    always_comb begin
        a_neg = md_a_signed(mdcontrol) & in_a[XLEN-1];
        b_neg = md_b_signed(mdcontrol) & in_b[XLEN-1];
        a_mag = a_neg ? -in_a : in_a;
        b_mag = b_neg ? -in_b : in_b;
        if ((mdcontrol == MD_REM) || (mdcontrol == MD_REMU)) begin
            neg_d = a_neg;
        end else if (md_is_div(mdcontrol)) begin
            neg_d = (a_neg ^ b_neg) & (in_b != '0);
        end else begin
            neg_d = a_neg ^ b_neg;
        end
    end

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_sh  = {hi_q, lo_q[XLEN-1]};
        div_ge  = (div_sh >= {1'b0, b_q});
        if (md_is_div(op_q)) begin
            hi_nx = div_ge ? div_sh[XLEN-1:0] - b_q : div_sh[XLEN-1:0];
            lo_nx = {lo_q[XLEN-2:0], div_ge};
        end else begin
            hi_nx = mul_sum[XLEN:1];
            lo_nx = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod_s = neg_q ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
        case (op_q)
            MD_MUL:                        final_res = prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  final_res = prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               final_res = neg_q ? -lo_nx : lo_nx;
            default:                       final_res = neg_q ? -hi_nx : hi_nx;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (accept) state_d = fast_take ? MD_FAST : MD_CALC;
            MD_CALC: if (last_iter) state_d = MD_DONE;
            MD_FAST: state_d = MD_DONE;
            MD_DONE: begin
                if (accept) begin
                    state_d = fast_take ? MD_FAST : MD_CALC;
                end else if (out_ready) begin
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
        if (flush) begin
            state_d = MD_IDLE;
        end
    end

    always_comb begin
        in_ready  = !flush & ((state_q == MD_IDLE) | ((state_q == MD_DONE) & out_ready));
        busy      = (state_q == MD_CALC);
        out_valid = (state_q == MD_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= MD_MUL;
            illegal_q <= 1'b0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
        end else if (accept) begin
            op_q      <= mdcontrol;
            illegal_q <= !md_legal(mdcontrol);
            neg_q     <= neg_d;
            cnt_q     <= '0;
            hi_q      <= spec_res;
            lo_q      <= a_mag;
            b_q       <= b_mag;
        end else if (state_q == MD_CALC) begin
            hi_q  <= hi_nx;
            lo_q  <= lo_nx;
            cnt_q <= cnt_q + 1'b1;
            if (last_iter) begin
                res_q <= final_res;
                err_q <= 1'b0;
            end
        end else if (state_q == MD_FAST) begin
            res_q <= illegal_q ? '0 : hi_q;
            err_q <= illegal_q;
        end
    end

    assign out_result = res_q;
    assign out_err    = err_q;

endmodule

// File: tb/tb_exec_muldiv.sv
// tb/tb_exec_muldiv.sv - scoreboard bench for exec_muldiv with directed vectors
`timescale 1ns/1ps
module tb_exec_muldiv;
    import riscv_defines::*;

    localparam int XLEN = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int SP_LAT = 1;
    localparam int SP_BSY = 0;
`else
    localparam int SP_LAT = XLEN;
    localparam int SP_BSY = XLEN;
`endif

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          lat;
        int          bsy;
        int          acc;
    } exp_t;

    typedef struct {
        mdcontrol_t  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          bsy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_err, busy;
    logic [31:0] in_a, in_b, out_result;
    mdcontrol_t  mdcontrol;

    exp_t sb[$];
    exp_t cur;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   run = 0;
    bit   seen = 1'b0;

    exec_muldiv #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mdcontrol  (mdcontrol),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares every presented result against the scoreboard head
    always @(negedge clk) begin
        #3;
        if (!rst_n) begin
            seen = 1'b0;
            run  = 0;
        end else begin
            if (busy) run++;
            else if (!out_valid) run = 0;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'(out_valid), 32'd0);
                end else begin
                    cur = sb[0];
                    if (!seen) begin
                        check("latency", 32'(cyc - cur.acc - 1), 32'(cur.lat));
                        check("busy_cycles", 32'(run), 32'(cur.bsy));
                        run  = 0;
                        seen = 1'b1;
                    end
                    check("result", out_result, cur.res);
                    check("err", 32'(out_err), 32'(cur.err));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    // Call at a negedge; returns just after the accepting edge
    task automatic issue(input mdcontrol_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic err, input int lat, input int bsy,
                         input bit push, output int waited);
        exp_t e;
        in_valid  = 1'b1;
        mdcontrol = op;
        in_a      = a;
        in_b      = b;
        #1;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        if (push) begin
            e.res = res;
            e.err = err;
            e.lat = lat;
            e.bsy = bsy;
            e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t v[10];
        int   w;
        v[0] = '{MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, SP_LAT, SP_BSY};
        v[1] = '{MD_REMU,   32'd5,        32'd0,        32'd5,        SP_LAT, SP_BSY};
        v[2] = '{MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SP_LAT, SP_BSY};
        v[3] = '{MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        SP_LAT, SP_BSY};
        v[4] = '{MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, XLEN,   XLEN};
        v[5] = '{MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, XLEN,   XLEN};
        v[6] = '{MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, XLEN,   XLEN};
        v[7] = '{MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, XLEN,   XLEN};
        v[8] = '{MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, XLEN,   XLEN};
        v[9] = '{MD_MUL,    32'd7,        32'hFFFFFFF9, 32'hFFFFFFCF, XLEN,   XLEN};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_a      = '0;
        in_b      = '0;
        mdcontrol = MD_MUL;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Back-pressure in DONE, then an illegal op accepted on the releasing cycle
        @(negedge clk);
        out_ready = 1'b0;
        issue(MD_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, XLEN, XLEN, 1'b1, w);
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            #2;
            w++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_result", out_result, 32'd14);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        issue(mdcontrol_t'(4'hB), 32'h1234, 32'h5678, 32'd0, 1'b1, 1, 0, 1'b1, w);
        check("illegal_accept_wait", 32'(w), 32'd0);
        check("handoff_valid", 32'(out_valid), 32'd0);
        drain();

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            issue(v[i].op, v[i].a, v[i].b, v[i].res, 1'b0, v[i].lat, v[i].bsy, 1'b1, w);
        end
        drain();

        // Flush on iteration 10
        @(negedge clk);
        issue(MD_MUL, 32'd3, 32'd5, 32'd0, 1'b0, 0, 0, 1'b0, w);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("calc_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        #2;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_in_ready_after", 32'(in_ready), 32'd1);
        for (int i = 0; i < 40; i++) begin
            check("flush_no_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
            #2;
        end

        // Reset mid-CALC
        @(negedge clk);
        issue(MD_DIV, 32'd1000, 32'd3, 32'd0, 1'b0, 0, 0, 1'b0, w);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_result", out_result, 32'd0);
        check("midrst_out_err", 32'(out_err), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #2;
            check("midrst_no_valid", 32'(out_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
